lamp_bank: RTL and testbench



---
 rtl/lamp_bank.sv | 106 ++++++++++
 tb/tb_lamp_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_bank.sv
// lamp_bank: CHANNELS independent push-button/lamp toggle FSMs with a global all-off and a lit-lamp count.
// Optional feature macro LAMP_AUTO_OFF_EN builds a per-channel auto-off timer (TIMEOUT cycles in ON_REL).
module lamp_bank #(
    parameter int CHANNELS = 4,
    parameter int TIMEOUT  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           B,
    input  logic                          all_off,
    output logic [CHANNELS-1:0]           L,
    output logic [CHANNELS-1:0]           s0,
    output logic [CHANNELS-1:0]           s1,
    output logic [$clog2(CHANNELS+1)-1:0] lit_count
);

    localparam int CW = $clog2(CHANNELS + 1);

    // Encoding is fixed so that bit 0 is the lamp and bit 1 is s1.
    typedef enum logic [1:0] {
        OFF_REL = 2'b00,
        ON_PR   = 2'b01,
        ON_REL  = 2'b11,
        OFF_PR  = 2'b10
    } state_e;

    if (CHANNELS < 1 || CHANNELS > 32 || TIMEOUT < 1) begin : g_param_check
        $error("lamp_bank: CHANNELS must be 1..32 and TIMEOUT >= 1");
    end

`ifdef LAMP_AUTO_OFF_EN
    localparam int TW = $clog2(TIMEOUT + 1);
`endif

    logic [CHANNELS-1:0] lamp_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            state_e state_q, state_d;
            logic   expire;

`ifdef LAMP_AUTO_OFF_EN
            logic [TW-1:0] timer_q, timer_d;

            // Expiry on the TIMEOUT-th ON_REL cycle keeps the lamp lit exactly TIMEOUT cycles.
            assign expire = (state_q == ON_REL) && (timer_q == TW'(TIMEOUT - 1));

            always_comb begin
                timer_d = '0;
                if (state_q == ON_REL && state_d == ON_REL) begin
                    timer_d = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + TW'(1);
                end
            end
`else
            assign expire = 1'b0;
`endif

            always_comb begin
                state_d = state_q;
                if (all_off) begin
                    state_d = B[gi] ? OFF_PR : OFF_REL;
                end else begin
                    case (state_q)
                        OFF_REL: if (B[gi])  state_d = ON_PR;
                        ON_PR:   if (!B[gi]) state_d = ON_REL;
                        ON_REL: begin
                            if (B[gi])       state_d = OFF_PR;
                            else if (expire) state_d = OFF_REL;
                        end
                        OFF_PR:  if (!B[gi]) state_d = OFF_REL;
                        default:             state_d = OFF_REL;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= OFF_REL;
`ifdef LAMP_AUTO_OFF_EN
                    timer_q <= '0;
`endif
                end else begin
                    state_q <= state_d;
`ifdef LAMP_AUTO_OFF_EN
                    timer_q <= timer_d;
`endif
                end
            end

            assign lamp_q[gi] = state_q[0];
            assign s0[gi]     = state_q[0];
            assign s1[gi]     = state_q[1];
        end
    endgenerate

    assign L = lamp_q;

    always_comb begin
        lit_count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lit_count = lit_count + CW'(lamp_q[i]);
        end
    end

endmodule

// File: tb/tb_lamp_bank.sv
// Directed bench for lamp_bank (CHANNELS=4, TIMEOUT=8); auto-off scenario selected by LAMP_AUTO_OFF_EN.
module tb_lamp_bank;

    localparam int CH = 4;
    localparam int CW = $clog2(CH + 1);

    typedef struct packed {
        logic       rst;
        logic       ao;
        logic [3:0] b;
        logic [3:0] es1;
        logic [3:0] es0;
        logic [2:0] elit;
    } step_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          all_off;
    logic [CH-1:0] B;
    logic [CH-1:0] L;
    logic [CH-1:0] s0;
    logic [CH-1:0] s1;
    logic [CW-1:0] lit_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lamp_bank #(.CHANNELS(CH), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .B(B), .all_off(all_off),
        .L(L), .s0(s0), .s1(s1), .lit_count(lit_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t tbl[5] = '{
            '{1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 3'd0},
            '{1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 3'd0},
            '{1'b0, 1'b0, 4'hF, 4'h0, 4'hF, 3'd4},
            '{1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 3'd4},
            '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 3'd0}
        };
        for (int i = 0; i < 5; i++) begin
            reset = tbl[i].rst; all_off = tbl[i].ao; B = tbl[i].b;
            tick();
            total++;
            if ({L, s1, s0, lit_count} !== {tbl[i].es0, tbl[i].es1, tbl[i].es0, tbl[i].elit}) begin
                bad++;
                $display("FAIL reset step %0d: got L=%b s1=%b s0=%b lit=%0d want L=%b s1=%b s0=%b lit=%0d",
                         i, L, s1, s0, lit_count, tbl[i].es0, tbl[i].es1, tbl[i].es0, tbl[i].elit);
            end else $display("reset step %0d ok L=%b s1=%b s0=%b lit=%0d", i, L, s1, s0, lit_count);
        end
    endtask

    task automatic test_toggle();
        step_t tbl[6] = '{
            '{1'b0, 1'b0, 4'h1, 4'h0, 4'h1, 3'd1},
            '{1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 3'd1},
            '{1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 3'd1},
            '{1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 3'd1},
            '{1'b0, 1'b0, 4'h1, 4'h1, 4'h0, 3'd0},
            '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0}
        };
        for (int i = 0; i < 6; i++) begin
            reset = tbl[i].rst; all_off = tbl[i].ao; B = tbl[i].b;
            tick();
            total++;
            if ({L, s1, s0, lit_count} !== {tbl[i].es0, tbl[i].es1, tbl[i].es0, tbl[i].elit}) begin
                bad++;
                $display("FAIL toggle step %0d: got L=%b s1=%b s0=%b lit=%0d want L=%b s1=%b s0=%b lit=%0d",
                         i, L, s1, s0, lit_count, tbl[i].es0, tbl[i].es1, tbl[i].es0, tbl[i].elit);
            end else $display("toggle step %0d ok L=%b s1=%b s0=%b lit=%0d", i, L, s1, s0, lit_count);
        end
    endtask

    task automatic test_simultaneous();
        step_t tbl[6] = '{
            '{1'b0, 1'b0, 4'h4, 4'h0, 4'h4, 3'd1},
            '{1'b0, 1'b0, 4'h0, 4'h4, 4'h4, 3'd1},
            '{1'b0, 1'b0, 4'hA, 4'h4, 4'hE, 3'd3},
            '{1'b0, 1'b0, 4'h0, 4'hE, 4'hE, 3'd3},
            '{1'b0, 1'b0, 4'h1, 4'hE, 4'hF, 3'd4},
            '{1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 3'd4}
        };
        for (int i = 0; i < 6; i++) begin
            reset = tbl[i].rst; all_off = tbl[i].ao; B = tbl[i].b;
            tick();
            total++;
            if ({L, s1, s0, lit_count} !== {tbl[i].es0, tbl[i].es1, tbl[i].es0, tbl[i].elit}) begin
                bad++;
                $display("FAIL simul step %0d: got L=%b s1=%b s0=%b lit=%0d want L=%b s1=%b s0=%b lit=%0d",
                         i, L, s1, s0, lit_count, tbl[i].es0, tbl[i].es1, tbl[i].es0, tbl[i].elit);
            end else $display("simul step %0d ok L=%b s1=%b s0=%b lit=%0d", i, L, s1, s0, lit_count);
        end
    endtask

    task automatic test_all_off();
        step_t tbl[7] = '{
            '{1'b0, 1'b1, 4'h4, 4'h4, 4'h0, 3'd0},
            '{1'b0, 1'b0, 4'h4, 4'h4, 4'h0, 3'd0},
            '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0},
            '{1'b0, 1'b0, 4'h4, 4'h0, 4'h4, 3'd1},
            '{1'b0, 1'b0, 4'h0, 4'h4, 4'h4, 3'd1},
            '{1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 3'd0},
            '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0}
        };
        for (int i = 0; i < 7; i++) begin
            reset = tbl[i].rst; all_off = tbl[i].ao; B = tbl[i].b;
            tick();
            total++;
            if ({L, s1, s0, lit_count} !== {tbl[i].es0, tbl[i].es1, tbl[i].es0, tbl[i].elit}) begin
                bad++;
                $display("FAIL alloff step %0d: got L=%b s1=%b s0=%b lit=%0d want L=%b s1=%b s0=%b lit=%0d",
                         i, L, s1, s0, lit_count, tbl[i].es0, tbl[i].es1, tbl[i].es0, tbl[i].elit);
            end else $display("alloff step %0d ok L=%b s1=%b s0=%b lit=%0d", i, L, s1, s0, lit_count);
        end
    endtask

    task automatic test_back_to_back();
        step_t tbl[9] = '{
            '{1'b0, 1'b0, 4'h2, 4'h0, 4'h2, 3'd1},
            '{1'b0, 1'b0, 4'h0, 4'h2, 4'h2, 3'd1},
            '{1'b0, 1'b0, 4'h2, 4'h2, 4'h0, 3'd0},
            '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0},
            '{1'b0, 1'b0, 4'h8, 4'h0, 4'h8, 3'd1},
            '{1'b0, 1'b0, 4'h2, 4'h8, 4'hA, 3'd2},
            '{1'b0, 1'b0, 4'h8, 4'hA, 4'h2, 3'd1},
            '{1'b0, 1'b0, 4'h0, 4'h2, 4'h2, 3'd1},
            '{1'b0, 1'b0, 4'h2, 4'h2, 4'h0, 3'd0}
        };
        for (int i = 0; i < 9; i++) begin
            reset = tbl[i].rst; all_off = tbl[i].ao; B = tbl[i].b;
            tick();
            total++;
            if ({L, s1, s0, lit_count} !== {tbl[i].es0, tbl[i].es1, tbl[i].es0, tbl[i].elit}) begin
                bad++;
                $display("FAIL b2b step %0d: got L=%b s1=%b s0=%b lit=%0d want L=%b s1=%b s0=%b lit=%0d",
                         i, L, s1, s0, lit_count, tbl[i].es0, tbl[i].es1, tbl[i].es0, tbl[i].elit);
            end else $display("b2b step %0d ok L=%b s1=%b s0=%b lit=%0d", i, L, s1, s0, lit_count);
        end
    endtask

    task automatic test_reset_mid();
        step_t tbl[8] = '{
            '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0},
            '{1'b0, 1'b0, 4'h1, 4'h0, 4'h1, 3'd1},
            '{1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 3'd1},
            '{1'b1, 1'b0, 4'h1, 4'h0, 4'h0, 3'd0},
            '{1'b1, 1'b0, 4'h1, 4'h0, 4'h0, 3'd0},
            '{1'b0, 1'b0, 4'h1, 4'h0, 4'h1, 3'd1},
            '{1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 3'd1},
            '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 3'd0}
        };
        for (int i = 0; i < 8; i++) begin
            reset = tbl[i].rst; all_off = tbl[i].ao; B = tbl[i].b;
            tick();
            total++;
            if ({L, s1, s0, lit_count} !== {tbl[i].es0, tbl[i].es1, tbl[i].es0, tbl[i].elit}) begin
                bad++;
                $display("FAIL rstmid step %0d: got L=%b s1=%b s0=%b lit=%0d want L=%b s1=%b s0=%b lit=%0d",
                         i, L, s1, s0, lit_count, tbl[i].es0, tbl[i].es1, tbl[i].es0, tbl[i].elit);
            end else $display("rstmid step %0d ok L=%b s1=%b s0=%b lit=%0d", i, L, s1, s0, lit_count);
        end
    endtask

`ifdef LAMP_AUTO_OFF_EN
    // Run 0 lets the timer expire; run 1 presses on the 8th ON_REL cycle.
    task automatic test_auto_off();
        logic [1:0] exp_st;
        for (int run = 0; run < 2; run++) begin
            reset = 1'b0; all_off = 1'b0;
            for (int i = 0; i < 11; i++) begin
                B = 4'h0;
                if (i == 0) B = 4'h1;
                if (run == 1 && i == 9) B = 4'h1;
                tick();
                if (i == 0)      exp_st = 2'b01;
                else if (i <= 8) exp_st = 2'b11;
                else if (i == 9) exp_st = (run == 1) ? 2'b10 : 2'b00;
                else             exp_st = 2'b00;
                total++;
                if ({s1[0], s0[0], L[0], s1[3:1], s0[3:1]} !== {exp_st, exp_st[0], 6'b0}) begin
                    bad++;
                    $display("FAIL autooff run %0d step %0d: got s1s0=%b%b L=%b want s1s0=%b others 0",
                             run, i, s1[0], s0[0], L[0], exp_st);
                end else $display("autooff run %0d step %0d ok s1s0=%b%b", run, i, s1[0], s0[0]);
            end
        end
    endtask
`else
    task automatic test_no_auto_off();
        reset = 1'b0; all_off = 1'b0;
        for (int i = 0; i < 52; i++) begin
            B = (i == 0) ? 4'h1 : 4'h0;
            tick();
            total++;
            if ({L, lit_count} !== {4'h1, 3'd1}) begin
                bad++;
                $display("FAIL holdon step %0d: got L=%b lit=%0d want L=0001 lit=1", i, L, lit_count);
            end else $display("holdon step %0d ok L=%b", i, L);
        end
        all_off = 1'b1;
        tick();
        all_off = 1'b0;
        total++;
        if (L !== 4'h0) begin
            bad++;
            $display("FAIL holdon alloff: got L=%b want L=0000", L);
        end else $display("holdon alloff ok L=%b", L);
    endtask
`endif

    initial begin
        reset = 1'b1; all_off = 1'b0; B = 4'hF;
        test_reset();
        test_toggle();
        test_simultaneous();
        test_all_off();
        test_back_to_back();
        test_reset_mid();
`ifdef LAMP_AUTO_OFF_EN
        test_auto_off();
`else
        test_no_auto_off();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
